uart_tx: RTL

//   Serial UART transmitter downstream of the memory-mapped IO block. Consumes

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the FSM state encoding and the default bit period.
package uart_tx_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        UART_TX_IDLE   = 3'd0,
        UART_TX_START  = 3'd1,
        UART_TX_DATA   = 3'd2,
        UART_TX_PARITY = 3'd3,
        UART_TX_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Emits a one-cycle tick on the last cycle of each bit period.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with rising-edge start request and done flag.
// Define UART_TX_PARITY_EN to insert an even parity bit before STOP.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_txd_data,
    input  logic       uart_transmit,
    output logic       uart_txd_done,
    output logic       uart_txd
);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     bit_q, bit_d;
    logic           txd_d;
    logic           done_d;
    logic           transmit_q;
    logic           start;
    logic           tick;
    logic           clr;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    assign start = uart_transmit & ~transmit_q
                 & (state_q == UART_TX_IDLE);
    assign clr   = (state_q == UART_TX_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    // Next-state logic; txd/done are computed here and registered below.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        txd_d   = uart_txd;
        done_d  = uart_txd_done;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            UART_TX_IDLE: begin
                if (start) begin
                    shreg_d = uart_txd_data;
                    bit_d   = 3'd0;
                    state_d = UART_TX_START;
                    txd_d   = 1'b0;
                    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^uart_txd_data;
`endif
                end
            end
            UART_TX_START: begin
                if (tick) begin
                    state_d = UART_TX_DATA;
                    txd_d   = shreg_q[0];
                end
            end
            UART_TX_DATA: begin
                if (tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_TX_PARITY;
                        txd_d   = par_q;
`else
                        state_d = UART_TX_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_TX_PARITY: begin
                if (tick) begin
                    state_d = UART_TX_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            UART_TX_STOP: begin
                if (tick) begin
                    state_d = UART_TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = UART_TX_IDLE;
                txd_d   = 1'b1;
                done_d  = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= UART_TX_IDLE;
            shreg_q       <= '0;
            bit_q         <= '0;
            uart_txd      <= 1'b1;
            uart_txd_done <= 1'b1;
            transmit_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_q         <= bit_d;
            uart_txd      <= txd_d;
            uart_txd_done <= done_d;
            transmit_q    <= uart_transmit;
`ifdef UART_TX_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

endmodule
